// File: rtl/datapath_ctrl_pkg.sv
// datapath_ctrl_pkg: shared FSM states, RV64 subset opcodes and the decoded-control record
package datapath_ctrl_pkg;
  typedef enum logic [3:0] {
    S_IDLE, S_INIT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_PCUPD, S_HALT
  } state_t;
  typedef enum logic [1:0] {K_NOP, K_WB, K_MEM, K_BR} kind_t;
  localparam logic [6:0] OP_LOAD = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_OP = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;
  localparam logic [2:0] F3_BLT = 3'b100;
  localparam logic [2:0] F3_BGE = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  localparam logic [2:0] F3_DWORD = 3'b011;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [6:0] F7_ADD = 7'b0000000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  typedef struct packed {
    kind_t kind;
    logic [4:0] ra;
    logic [4:0] rb;
    logic [4:0] rw;
    logic [63:0] imm;
    logic [63:0] br_off;
    logic [2:0] funct3;
    logic d0;
    logic d1;
    logic d2;
    logic sub;
  } dec_t;
  function automatic logic [63:0] sext12(input logic [11:0] v);
    return {{52{v[11]}}, v};
  endfunction
endpackage

// File: rtl/datapath_ctrl_decode.sv
// datapath_ctrl_decode: combinational IR decode into datapath selects plus a legal-encoding flag
module datapath_ctrl_decode import datapath_ctrl_pkg::*; #(
  parameter int BR_SHIFT = 2
) (
  input logic [31:0] ir,
  output dec_t dec,
  output logic legal
);
  logic [6:0] op, f7;
  logic [2:0] f3;
  logic [4:0] rd, rs1, rs2;
  logic [63:0] b_imm;
  assign {f7, rs2, rs1, f3, rd, op} = ir;
  assign b_imm = {{51{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  // Anything not matched below stays all-zero and is flagged illegal (retired as NOP or trapped)
  always_comb begin
    dec = '0;
    legal = 1'b0;
    if (op == OP_LOAD && f3 == F3_DWORD) begin
      legal = 1'b1;
      dec.kind = K_WB;
      dec.ra = rs1;
      dec.rw = rd;
      dec.imm = sext12(ir[31:20]);
      dec.d0 = 1'b1;
      dec.d1 = 1'b1;
      dec.d2 = 1'b1;
    end else if (op == OP_STORE && f3 == F3_DWORD) begin
      legal = 1'b1;
      dec.kind = K_MEM;
      dec.rb = rs1;
      dec.ra = rs2;
      dec.imm = sext12({f7, rd});
      dec.d0 = 1'b1;
      dec.d2 = 1'b1;
    end else if (op == OP_OP && f3 == F3_ADD && (f7 == F7_ADD || f7 == F7_SUB)) begin
      legal = 1'b1;
      dec.kind = K_WB;
      dec.ra = rs1;
      dec.rb = rs2;
      dec.rw = rd;
      dec.d1 = 1'b1;
      dec.sub = f7[5];
    end else if (op == OP_IMM && f3 == F3_ADD) begin
      legal = 1'b1;
      dec.kind = K_WB;
      dec.ra = rs1;
      dec.rw = rd;
      dec.imm = sext12(ir[31:20]);
      dec.d0 = 1'b1;
      dec.d1 = 1'b1;
    end else if (op == OP_BRANCH && f3 != 3'b010 && f3 != 3'b011) begin
      legal = 1'b1;
      dec.kind = K_BR;
      dec.ra = rs1;
      dec.rb = rs2;
      dec.d1 = 1'b1;
      dec.sub = 1'b1;
      dec.funct3 = f3;
      dec.br_off = $signed(b_imm) >>> BR_SHIFT;
    end
  end
endmodule

// File: rtl/datapath_ctrl.sv
// datapath_ctrl: multi-cycle RV64-subset control FSM for the 64-bit datapath; DATAPATH_CTRL_TRAP_EN halts on illegal encodings
module datapath_ctrl import datapath_ctrl_pkg::*; #(
  parameter logic [63:0] RESET_PC = 64'd0,
  parameter logic [63:0] PC_STEP = 64'd1,
  parameter int BR_SHIFT = 2
) (
  input logic clk,
  input logic reset,
  input logic start,
  output logic busy,
  output logic halted,
  input logic [31:0] saida_IR,
  input logic BEQ,
  input logic BNE,
  input logic BLT,
  input logic BGE,
  input logic BLTU,
  input logic BGEU,
  output logic we,
  output logic we_ram,
  output logic load_PC,
  output logic load_IR,
  output logic [63:0] PCres,
  output logic [63:0] somador_PC,
  output logic [4:0] Ra,
  output logic [4:0] Rb,
  output logic [4:0] Rw,
  output logic [63:0] entrada_mux_add_sub,
  output logic decisor0,
  output logic decisor1,
  output logic decisor2,
  output logic decisor3,
  output logic somador_subtrator,
  output logic [31:0] instr_count
);
  state_t state, state_nx;
  dec_t dec, ctrl;
  logic legal, taken;
  datapath_ctrl_decode #(.BR_SHIFT(BR_SHIFT)) u_decode (.ir(saida_IR), .dec(dec), .legal(legal));
  assign taken = ctrl.funct3 == F3_BEQ ? BEQ :
                 ctrl.funct3 == F3_BNE ? BNE :
                 ctrl.funct3 == F3_BLT ? BLT :
                 ctrl.funct3 == F3_BGE ? BGE :
                 ctrl.funct3 == F3_BLTU ? BLTU :
                 ctrl.funct3 == F3_BGEU ? BGEU : 1'b0;
  // State register
  always_ff @(posedge clk) state <= reset ? S_IDLE : state_nx;
  // Next-state: start is only honoured while idle or halted
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_HALT: state_nx = start ? S_INIT : state;
      S_INIT: state_nx = S_FETCH;
      S_FETCH: state_nx = S_DECODE;
`ifdef DATAPATH_CTRL_TRAP_EN
      S_DECODE: state_nx = legal ? S_EXEC : S_HALT;
`else
      S_DECODE: state_nx = S_EXEC;
`endif
      S_EXEC: state_nx = ctrl.kind == K_WB ? S_WB : ctrl.kind == K_MEM ? S_MEM : S_PCUPD;
      S_MEM, S_WB: state_nx = S_PCUPD;
      S_PCUPD: state_nx = S_FETCH;
      default: state_nx = S_IDLE;
    endcase
  end
  // Selects latch in DECODE, branch offset resolves in EXEC once flags settle, count on retire
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
      somador_PC <= PC_STEP;
      instr_count <= '0;
    end else begin
      if (state == S_DECODE) ctrl <= legal ? dec : '0;
      if (state == S_EXEC) somador_PC <= (ctrl.kind == K_BR && taken) ? ctrl.br_off : PC_STEP;
      if (state == S_PCUPD) instr_count <= instr_count + 32'd1;
    end
  end
  // Per-state strobes, masked during reset so an interrupted WB/MEM never pulses
  always_comb begin
    busy = state != S_IDLE && state != S_HALT;
    halted = state == S_HALT;
    we = !reset && state == S_WB && ctrl.rw != 5'd0;
    we_ram = !reset && state == S_MEM;
    load_PC = !reset && (state == S_INIT || state == S_PCUPD);
    load_IR = !reset && state == S_FETCH;
    decisor3 = !reset && state == S_PCUPD;
  end
  assign PCres = RESET_PC;
  assign Ra = ctrl.ra;
  assign Rb = ctrl.rb;
  assign Rw = ctrl.rw;
  assign entrada_mux_add_sub = ctrl.imm;
  assign decisor0 = ctrl.d0;
  assign decisor1 = ctrl.d1;
  assign decisor2 = ctrl.d2;
  assign somador_subtrator = ctrl.sub;
endmodule

// File: tb/tb_datapath_ctrl.sv
// tb_datapath_ctrl: table vectors, reset/trap sequences and random instructions against a field-level model
module tb_datapath_ctrl;
  localparam int KW = 0, KM = 1, KB = 2, KN = 3;
  typedef struct {
    logic [31:0] ir;
    logic [5:0] flags;
    int kind;
    logic [4:0] ra, rb, rw;
    logic [63:0] imm;
    logic d0, d1, d2, sub;
    logic [63:0] som;
    logic [7:0] care;
  } vec_t;
  logic clk, reset, start;
  logic [31:0] IR;
  logic [5:0] flags;
  logic busy, halted, we, we_ram, load_PC, load_IR;
  logic [63:0] PCres, somador_PC, entrada_mux_add_sub;
  logic [4:0] Ra, Rb, Rw;
  logic decisor0, decisor1, decisor2, decisor3, somador_subtrator;
  logic [31:0] instr_count;
  int n_cmp = 0, n_bad = 0;
  logic [31:0] cnt_m = 0;
  string tag = "rst";
  vec_t vt [13];
  datapath_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .halted(halted), .saida_IR(IR),
    .BEQ(flags[5]), .BNE(flags[4]), .BLT(flags[3]), .BGE(flags[2]), .BLTU(flags[1]), .BGEU(flags[0]),
    .we(we), .we_ram(we_ram), .load_PC(load_PC), .load_IR(load_IR), .PCres(PCres),
    .somador_PC(somador_PC), .Ra(Ra), .Rb(Rb), .Rw(Rw), .entrada_mux_add_sub(entrada_mux_add_sub),
    .decisor0(decisor0), .decisor1(decisor1), .decisor2(decisor2), .decisor3(decisor3),
    .somador_subtrator(somador_subtrator), .instr_count(instr_count)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s/%s: got %0h, want %0h", tag, n, a, e);
    end
  endtask
  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3, input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [4:0] rs1, input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, rs1, 3'b011, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    return {f7, rs2, rs1, 3'b000, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [4:0] rs1, input logic [4:0] rs2, input logic [12:0] imm);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic vec_t mk(input logic [31:0] ir, input logic [5:0] fl, input int kind, input logic [4:0] ra, input logic [4:0] rb,
                              input logic [4:0] rw, input logic [63:0] imm, input logic d0, input logic d1, input logic d2,
                              input logic sub, input logic [63:0] som, input logic [7:0] care);
    vec_t v;
    v.ir = ir; v.flags = fl; v.kind = kind; v.ra = ra; v.rb = rb; v.rw = rw; v.imm = imm;
    v.d0 = d0; v.d1 = d1; v.d2 = d2; v.sub = sub; v.som = som; v.care = care;
    return v;
  endfunction
  function automatic vec_t rnd_vec();
    vec_t v;
    int t, i12, bi, q, idx;
    logic [4:0] r1, r2, rd;
    logic [2:0] f3;
    logic s;
    r1 = 5'($urandom); r2 = 5'($urandom); rd = 5'($urandom);
    i12 = int'($urandom_range(0, 4095)) - 2048;
    bi = 2 * (int'($urandom_range(0, 4095)) - 2048);
    v = mk(32'hFFFF_FFFF, 6'($urandom), KN, 0, 0, 0, 0, 0, 0, 0, 0, 64'd1, 8'h00);
    t = $urandom_range(0, 6);
`ifdef DATAPATH_CTRL_TRAP_EN
    if (t == 6) t = 4;
`endif
    case (t)
      0: begin
        v.ir = enc_i(7'b0000011, 3'b011, rd, r1, 12'(i12));
        v.kind = KW; v.ra = r1; v.rw = rd; v.imm = 64'(longint'(i12)); v.d0 = 1; v.d1 = 1; v.d2 = 1; v.care = 8'hBE;
      end
      1: begin
        v.ir = enc_s(r1, r2, 12'(i12));
        v.kind = KM; v.ra = r2; v.rb = r1; v.imm = 64'(longint'(i12)); v.d0 = 1; v.d1 = 0; v.d2 = 1; v.care = 8'hDE;
      end
      2: begin
        s = 1'($urandom);
        v.ir = enc_r(s ? 7'b0100000 : 7'b0000000, rd, r1, r2);
        v.kind = KW; v.ra = r1; v.rb = r2; v.rw = rd; v.d0 = 0; v.d1 = 1; v.d2 = 0; v.sub = s; v.care = 8'hEF;
      end
      3: begin
        v.ir = enc_i(7'b0010011, 3'b000, rd, r1, 12'(i12));
        v.kind = KW; v.ra = r1; v.rw = rd; v.imm = 64'(longint'(i12)); v.d0 = 1; v.d1 = 1; v.d2 = 0; v.sub = 0; v.care = 8'hBF;
      end
      4, 5: begin
        idx = $urandom_range(0, 5);
        f3 = idx < 2 ? 3'(idx) : 3'(idx + 2);
        v.ir = enc_b(f3, r1, r2, 13'(bi));
        v.kind = KB; v.ra = r1; v.rb = r2; v.d0 = 0; v.d1 = 1; v.sub = 1; v.care = 8'hCD;
        q = bi / 4;
        if (bi < 0 && bi % 4 != 0) q--;
        v.som = v.flags[5 - idx] ? 64'(longint'(q)) : 64'd1;
      end
      default: begin
        case ($urandom_range(0, 3))
          0: v.ir = {25'($urandom), 7'b1111111};
          1: v.ir = enc_i(7'b0000011, 3'b000, rd, r1, 12'(i12));
          2: v.ir = enc_b(3'b010, r1, r2, 13'(bi));
          default: v.ir = enc_r(7'b0000001, rd, r1, r2);
        endcase
      end
    endcase
    return v;
  endfunction
  task automatic check_reset_vals();
    chk("rst_strobes", {busy, halted, we, we_ram, load_PC, load_IR, decisor0, decisor1, decisor2, decisor3, somador_subtrator}, 0);
    chk("rst_pcres", PCres, 64'd0);
    chk("rst_som", somador_PC, 64'd1);
    chk("rst_regs", {Ra, Rb, Rw}, 0);
    chk("rst_imm", entrada_mux_add_sub, 0);
    chk("rst_count", instr_count, 0);
  endtask
  task automatic do_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    chk("init_ldpc", load_PC, 1);
    chk("init_d3", decisor3, 0);
    chk("init_pcres", PCres, 64'd0);
    chk("init_busy", busy, 1);
  endtask
  task automatic exec(input vec_t v, input bit jam);
    int lat, nwe, nram, wpos;
    IR = v.ir; flags = v.flags;
    lat = -1; nwe = 0; nram = 0; wpos = -1;
`ifdef DATAPATH_CTRL_TRAP_EN
    if (v.kind == KN) begin
      @(negedge clk); chk("fetch", load_IR, 1); chk("count", instr_count, cnt_m);
      @(negedge clk);
      repeat (2) begin
        @(negedge clk);
        chk("halted", halted, 1); chk("halt_busy", busy, 0); chk("halt_ldpc", load_PC, 0); chk("halt_cnt", instr_count, cnt_m);
      end
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(negedge clk); chk("reinit_ldpc", load_PC, 1); chk("reinit_d3", decisor3, 0);
      return;
    end
`endif
    for (int k = 0; k < 10 && lat < 0; k++) begin
      @(negedge clk);
      if (jam) start = 1'($urandom);
      if (k == 0) begin chk("fetch", load_IR, 1); chk("count", instr_count, cnt_m); end
      if (k == 1) chk("busy", busy, 1);
      if (we) begin nwe++; wpos = k; chk("we_rw", Rw, v.rw); end
      if (we_ram) nram++;
      if (load_PC) begin
        lat = k + 1;
        chk("d3", decisor3, 1);
        chk("som", somador_PC, v.som);
        if (v.care[7]) chk("ra", Ra, v.ra);
        if (v.care[6]) chk("rb", Rb, v.rb);
        if (v.care[5]) chk("rw", Rw, v.rw);
        if (v.care[4]) chk("imm", entrada_mux_add_sub, v.imm);
        if (v.care[3]) chk("d0", decisor0, v.d0);
        if (v.care[2]) chk("d1", decisor1, v.d1);
        if (v.care[1]) chk("d2", decisor2, v.d2);
        if (v.care[0]) chk("sub", somador_subtrator, v.sub);
      end
    end
    start = 1'b0;
    chk("latency", lat, (v.kind == KW || v.kind == KM) ? 5 : 4);
    chk("we_pulses", nwe, (v.kind == KW && v.rw != 0) ? 1 : 0);
    if (v.kind == KW && v.rw != 0) chk("we_cycle", wpos, 3);
    chk("ram_pulses", nram, v.kind == KM ? 1 : 0);
    cnt_m++;
  endtask
  initial begin
    vt[0] = mk(enc_i(7'b0000011, 3'b011, 2, 0, 0), 6'b000000, KW, 0, 0, 2, 64'd0, 1, 1, 1, 0, 64'd1, 8'hBE);
    vt[1] = mk(enc_i(7'b0010011, 3'b000, 1, 2, 9), 6'b111111, KW, 2, 0, 1, 64'd9, 1, 1, 0, 0, 64'd1, 8'hBF);
    vt[2] = mk(enc_r(7'b0100000, 7, 6, 3), 6'b000000, KW, 6, 3, 7, 64'd0, 0, 1, 0, 1, 64'd1, 8'hEF);
    vt[3] = mk(enc_i(7'b0010011, 3'b000, 0, 0, 5), 6'b000000, KW, 0, 0, 0, 64'd5, 1, 1, 0, 0, 64'd1, 8'hBF);
    vt[4] = mk(enc_b(3'b001, 2, 4, 13'd12), 6'b010000, KB, 2, 4, 0, 64'd0, 0, 1, 0, 1, 64'd3, 8'hCD);
    vt[5] = mk(enc_b(3'b001, 2, 4, 13'd12), 6'b101111, KB, 2, 4, 0, 64'd0, 0, 1, 0, 1, 64'd1, 8'hCD);
    vt[6] = mk(enc_s(2, 7, 12'd0), 6'b000000, KM, 7, 2, 0, 64'd0, 1, 0, 1, 0, 64'd1, 8'hDE);
    vt[7] = mk(enc_r(7'b0000000, 5, 1, 2), 6'b000000, KW, 1, 2, 5, 64'd0, 0, 1, 0, 0, 64'd1, 8'hEF);
    vt[8] = mk(enc_b(3'b000, 1, 1, 13'h1FF8), 6'b100000, KB, 1, 1, 0, 64'd0, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 8'hCD);
    vt[9] = mk(enc_b(3'b111, 3, 5, 13'h1000), 6'b000001, KB, 3, 5, 0, 64'd0, 0, 1, 0, 1, 64'hFFFF_FFFF_FFFF_FC00, 8'hCD);
    vt[10] = mk(32'hFFFF_FFFF, 6'b000000, KN, 0, 0, 0, 64'd0, 0, 0, 0, 0, 64'd1, 8'h00);
    vt[11] = mk(enc_i(7'b0000011, 3'b011, 3, 4, 12'hFFF), 6'b000000, KW, 4, 0, 3, 64'hFFFF_FFFF_FFFF_FFFF, 1, 1, 1, 0, 64'd1, 8'hBE);
    vt[12] = mk(enc_s(10, 9, 12'hFF0), 6'b000000, KM, 9, 10, 0, 64'hFFFF_FFFF_FFFF_FFF0, 1, 0, 1, 0, 64'd1, 8'hDE);
    reset = 1'b1; start = 1'b0; IR = '0; flags = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    tag = "start";
    do_start();
    for (int i = 0; i < 13; i++) begin
      tag = $sformatf("vec%0d", i);
      exec(vt[i], 1'b0);
    end
    tag = "rst_in_wb";
    IR = vt[1].ir;
    repeat (3) @(negedge clk);
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("we_masked", we, 0);
    chk("ldpc_masked", load_PC, 0);
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_reset_vals();
    cnt_m = 0;
    do_start();
    for (int i = 0; i < 60; i++) begin
      tag = $sformatf("rnd%0d", i);
      exec(rnd_vec(), 1'b1);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/datapath_ctrl.md
Name: datapath_ctrl

Overview:
- Multi-cycle control FSM that sequences the existing 64-bit `datapath`.
- Fetches from instruction memory via IR, decodes RV64 subset LD/SD/ADD/SUB/ADDI/BEQ/BNE/BLT/BGE/BLTU/BGEU, and drives the register-file, RAM, mux selects and PC controls.
- Sits between a top-level run/halt interface and `datapath`; replaces hand-driven bench stimulus.

Parameters:
- RESET_PC, 0, PC value loaded after start (instruction-indexed).
- PC_STEP, 1, sequential PC increment.
- BR_SHIFT, 2, arithmetic right shift applied to sign-extended B-immediate to form the instruction-indexed branch offset.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- start  in  1  pulse; leaves IDLE/HALT.
- busy  out  1  high in every state except IDLE/HALT.
- halted  out  1  high in HALT.
- saida_IR  in  32  IR contents.
- BEQ, BNE, BLT, BGE, BLTU, BGEU  in  1 each  datapath comparison flags (port A vs port B).
- we  out  1  register-file write enable.
- we_ram  out  1  data RAM write enable.
- load_PC  out  1  PC load.
- load_IR  out  1  IR load.
- PCres  out  64  absolute PC value (used when decisor3=0).
- somador_PC  out  64  PC increment (used when decisor3=1).
- Ra, Rb, Rw  out  5 each  register addresses.
- entrada_mux_add_sub  out  64  sign-extended immediate.
- decisor0  out  1  ALU B: 1=immediate, 0=port B.
- decisor1  out  1  ALU A: 1=port A, 0=port B.
- decisor2  out  1  writeback: 1=RAM data, 0=ALU.
- decisor3  out  1  PC source: 1=PC+somador_PC, 0=PCres.
- somador_subtrator  out  1  1=subtract.
- instr_count  out  32  retired instructions.

Behaviour:
- Reset: state=IDLE. All enables/decisors=0, PCres=RESET_PC, somador_PC=PC_STEP, Ra/Rb/Rw=0, immediate=0, instr_count=0, busy=0, halted=0.
- States:
  - IDLE: start → INIT.
  - INIT: load_PC=1, decisor3=0, PCres=RESET_PC → FETCH.
  - FETCH: load_IR=1 → DECODE.
  - DECODE: register all selects from saida_IR; outputs stay stable until the next DECODE → EXEC.
  - EXEC: ALU/flag settle cycle, no enables.
    - LD/ADD/SUB/ADDI → WB.
    - SD → MEM.
    - Branch → PCUPD.
  - MEM: we_ram=1 for one cycle → PCUPD.
  - WB: we=1 for one cycle → PCUPD.
  - PCUPD: load_PC=1, decisor3=1, instr_count++ → FETCH.
- Latency: 5 cycles per ALU/load/store instruction (FETCH, DECODE, EXEC, WB/MEM, PCUPD); 4 for branches.
- Decode settings:
  - LD: Ra=rs1, Rw=rd, imm=I-imm, d0=1, d1=1, d2=1.
  - SD: Rb=rs1, Ra=rs2, imm=S-imm, d0=1, d1=0, d2=1.
  - ADD/SUB: Ra=rs1, Rb=rs2, Rw=rd, d0=0, d1=1, d2=0; somador_subtrator=funct7[5].
  - ADDI: as LD with d2=0, somador_subtrator=0.
  - Branch: Ra=rs1, Rb=rs2, d0=0, d1=1, somador_subtrator=1.
- Branch resolution: in EXEC, somador_PC = taken ? (sext(B-imm) >>> BR_SHIFT) : PC_STEP, where taken selects the funct3-matching flag. For all non-branch instructions somador_PC=PC_STEP.
- Writes to rd=0: `we` is suppressed; instruction still retires.
- instr_count wraps at 2^32-1.
- start while busy is ignored.
- reset mid-instruction: immediate return to IDLE; no partial we/we_ram pulse is issued in the reset cycle.
- Unsupported opcode/funct3: NOP (skips to PCUPD from EXEC) unless the Optional Feature is enabled.

Optional Feature:
- Macro: DATAPATH_CTRL_TRAP_EN.
- With it: unsupported encoding in DECODE → HALT.
  - HALT: no enables, halted=1, PC not advanced, instr_count not incremented.
  - Exit via start → INIT, or via reset.
- Without it: unsupported encodings retire as NOP and HALT is unreachable.

Decomposition:
- Package datapath_ctrl_pkg: state enum, opcode constants (LOAD 0000011, STORE 0100011, OP 0110011, OP_IMM 0010011, BRANCH 1100011), branch funct3 constants, decoded-control struct.
- Sub-module datapath_ctrl_decode: combinational saida_IR → decoded-control struct plus legal flag.

Test Plan:
- Reset then start with IR=LD x2,0(x0): INIT then FETCH; WB cycle has we=1, Rw=2, Ra=0, d0/d1/d2=1, imm=0; instr_count=1 after PCUPD.
- ADDI x1,x2,9: imm=9, d2=0, somador_subtrator=0, single we pulse in cycle 4 after FETCH.
- SUB x7,x6,x3: somador_subtrator=1, d0=0, Ra=6, Rb=3, Rw=7; ADDI x0,x0,5: no we pulse.
- BNE x2,x4,+12 with BNE=1: somador_PC=3, decisor3=1, load_PC in PCUPD. With BNE=0: somador_PC=1. No we/we_ram in either case.
- SD x7,0(x2): we_ram one cycle with Ra=7, Rb=2, d1=0; we never asserted.
- Reset asserted during WB: no we that cycle, all outputs at reset values next cycle. Illegal opcode 1111111 with DATAPATH_CTRL_TRAP_EN: halted=1, instr_count unchanged.
